// File: rtl/sobel_window_ctrl_pkg.sv
// Shared types and widths for the Sobel window sequencer.
package sobel_window_ctrl_pkg;

   localparam int COORD_W = 10;
   localparam int PIX_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   // One entry of the output-tag pipeline: travels alongside the Sobel stage.
   typedef struct packed {
      logic               valid;
      logic               border;
      logic [COORD_W-1:0] cx;
      logic [COORD_W-1:0] cy;
   } tag_t;

endpackage

// File: rtl/sobel_window_ctrl_line_buffer.sv
// Single-port line store, read-before-write. The read is asynchronous so the
// old entry at the write address is available in the same accept cycle, both
// for the window and for forwarding into the next-older line.
module line_buffer
   import sobel_window_ctrl_pkg::*;
#(
   parameter int DEPTH  = 640,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [PIX_W-1:0]  wdata,
   output logic [PIX_W-1:0]  rdata
);

   logic [PIX_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   // Write the new pixel; the old contents were already presented on rdata.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequences a raster pixel stream into a 3x3 window for an external Sobel
// stage and re-tags its results with centre coordinates and a border flag.
module sobel_window_ctrl
   import sobel_window_ctrl_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int SOBEL_LAT  = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               pix_valid,
   input  logic [PIX_W-1:0]   pix_in,
   output logic [PIX_W-1:0]   z0,
   output logic [PIX_W-1:0]   z1,
   output logic [PIX_W-1:0]   z2,
   output logic [PIX_W-1:0]   z3,
   output logic [PIX_W-1:0]   z4,
   output logic [PIX_W-1:0]   z5,
   output logic [PIX_W-1:0]   z6,
   output logic [PIX_W-1:0]   z7,
   output logic [PIX_W-1:0]   z8,
   input  logic [PIX_W-1:0]   edge_in,
   output logic               out_valid,
   output logic [PIX_W-1:0]   out_pixel,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic               frame_done,
   output logic               busy
);

   localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int CNT_W  = (SOBEL_LAT > 1) ? $clog2(SOBEL_LAT) : 1;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);
   localparam logic [CNT_W-1:0]   F_LAST = CNT_W'(SOBEL_LAT - 1);

   state_t             state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic               frame_done_q, frame_done_d;
   logic               tags_clear;
   logic               accept;
   logic [PIX_W-1:0]   win_q [9];
   logic [PIX_W-1:0]   win_d [9];
   logic [PIX_W-1:0]   row1_rd, row2_rd;
   tag_t               tag_new;
   tag_t               tag_q [SOBEL_LAT];
   tag_t               tag_d [SOBEL_LAT];

   // frame_start takes precedence over a coincident pixel.
   assign accept = pix_valid && !frame_start &&
                   ((state_q == ST_FILL) || (state_q == ST_RUN));

   // Row y-1 store: its old entry moves on to the row y-2 store.
   line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(ADDR_W)) u_row1 (
      .clk   (clock),
      .we    (accept),
      .addr  (x_q[ADDR_W-1:0]),
      .wdata (pix_in),
      .rdata (row1_rd)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(ADDR_W)) u_row2 (
      .clk   (clock),
      .we    (accept),
      .addr  (x_q[ADDR_W-1:0]),
      .wdata (row1_rd),
      .rdata (row2_rd)
   );

   // Next-state, raster counters and flush timing.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      flush_cnt_d  = flush_cnt_q;
      frame_done_d = 1'b0;
      tags_clear   = 1'b0;
      if (frame_start) begin
         state_d     = ST_FILL;
         x_d         = '0;
         y_d         = '0;
         flush_cnt_d = '0;
         tags_clear  = 1'b1;
      end else begin
         case (state_q)
            ST_FILL, ST_RUN: begin
               if (accept) begin
                  if (x_q == X_LAST) begin
                     x_d = '0;
                     y_d = y_q + COORD_W'(1);
                  end else begin
                     x_d = x_q + COORD_W'(1);
                  end
                  if ((state_q == ST_FILL) && (x_q == X_LAST) && (y_q == COORD_W'(1))) begin
                     state_d = ST_RUN;
                  end
                  if ((state_q == ST_RUN) && (x_q == X_LAST) && (y_q == Y_LAST)) begin
                     state_d     = ST_FLUSH;
                     flush_cnt_d = '0;
                  end
               end
            end
            ST_FLUSH: begin
               if (flush_cnt_q == F_LAST) begin
                  state_d      = ST_IDLE;
                  frame_done_d = 1'b1;
               end else begin
                  flush_cnt_d = flush_cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Window shifts left on each accept; new right column is rows y-2, y-1, y.
   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]     = win_q[3*r + 1];
            win_d[3*r + 1] = win_q[3*r + 2];
         end
         win_d[2] = row2_rd;
         win_d[5] = row1_rd;
         win_d[8] = pix_in;
      end
   end

   // Tag for the window just formed; its centre sits at (x-1, y-1). A window
   // centred left of column 0 straddles the line wrap and yields no output.
   always_comb begin
      tag_new = '0;
      if (accept && (x_q != '0) && (y_q != '0)) begin
         tag_new.valid  = 1'b1;
         tag_new.border = !((x_q >= COORD_W'(2)) && (y_q >= COORD_W'(2)));
         tag_new.cx     = x_q - COORD_W'(1);
         tag_new.cy     = y_q - COORD_W'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < SOBEL_LAT; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            assign tag_d[gi] = tags_clear ? tag_t'('0) : tag_new;
         end else begin : g_body
            assign tag_d[gi] = tags_clear ? tag_t'('0) : tag_q[gi-1];
         end
      end
   endgenerate

   // State, counters, window and tag pipeline registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         flush_cnt_q  <= '0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
         for (int i = 0; i < SOBEL_LAT; i++) tag_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         flush_cnt_q  <= flush_cnt_d;
         frame_done_q <= frame_done_d;
         for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
         for (int i = 0; i < SOBEL_LAT; i++) tag_q[i] <= tag_d[i];
      end
   end

   assign z0 = win_q[0];
   assign z1 = win_q[1];
   assign z2 = win_q[2];
   assign z3 = win_q[3];
   assign z4 = win_q[4];
   assign z5 = win_q[5];
   assign z6 = win_q[6];
   assign z7 = win_q[7];
   assign z8 = win_q[8];

   assign out_valid  = tag_q[SOBEL_LAT-1].valid;
   assign out_x      = tag_q[SOBEL_LAT-1].cx;
   assign out_y      = tag_q[SOBEL_LAT-1].cy;
   assign out_pixel  = !out_valid ? '0 :
                       (tag_q[SOBEL_LAT-1].border ? 8'hFF : edge_in);
   assign frame_done = frame_done_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 4x3 image with a 3-cycle Sobel
// model (the z registers are its first stage, two more registers follow).
module tb_sobel_window_ctrl;
   import sobel_window_ctrl_pkg::*;

   localparam int W   = 4;
   localparam int H   = 3;
   localparam int LAT = 3;

   logic       clock = 1'b0;
   logic       reset, frame_start, pix_valid;
   logic [7:0] pix_in, edge_in, out_pixel;
   logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
   logic       out_valid, frame_done, busy;
   logic [9:0] out_x, out_y;

   int n_checks = 0;
   int n_errors = 0;
   int q_x[$], q_y[$], q_p[$];
   int done_cnt = 0;
   int done_ref;
   int exp_pix [6];
   logic [7:0] pat [12];
   logic [71:0] s0_q, s1_q;

   sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SOBEL_LAT(LAT)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start),
      .pix_valid(pix_valid), .pix_in(pix_in),
      .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7), .z8(z8),
      .edge_in(edge_in), .out_valid(out_valid), .out_pixel(out_pixel),
      .out_x(out_x), .out_y(out_y), .frame_done(frame_done), .busy(busy)
   );

   always #5 clock = ~clock;

   // Behavioural Sobel: |Gx|+|Gy| > 160 marks an edge as 8'h00, else 8'hFF.
   function automatic logic [7:0] sobel_ref(input logic [71:0] w);
      int p [9];
      int gx, gy;
      for (int i = 0; i < 9; i++) p[i] = {24'd0, w[i*8 +: 8]};
      gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      return ((gx + gy) > 160) ? 8'h00 : 8'hFF;
   endfunction

   always @(posedge clock) begin
      s0_q <= {z8, z7, z6, z5, z4, z3, z2, z1, z0};
      s1_q <= s0_q;
   end
   assign edge_in = sobel_ref(s1_q);

   // Output monitor, sampled on the falling edge.
   always @(negedge clock) begin
      if (out_valid) begin
         q_x.push_back(int'(out_x));
         q_y.push_back(int'(out_y));
         q_p.push_back(int'(out_pixel));
      end
      if (frame_done) done_cnt <= done_cnt + 1;
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start_frame;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic feed(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         pix_valid = 1'b1;
         pix_in    = pat[i];
         tick();
         if (gaps) begin
            pix_valid = 1'b0;
            pix_in    = 8'hA5;
            tick();
         end
      end
      pix_valid = 1'b0;
   endtask

   task automatic check_outputs(input string name);
      chk($sformatf("%s count", name), q_p.size(), 6);
      for (int k = 0; k < 6 && k < q_p.size(); k++) begin
         chk($sformatf("%s x[%0d]", name, k), q_x[k], k % 3);
         chk($sformatf("%s y[%0d]", name, k), q_y[k], k / 3);
         chk($sformatf("%s pix[%0d]", name, k), q_p[k], exp_pix[k]);
      end
   endtask

   initial begin
      reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;
      repeat (3) tick();
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst out_pixel", int'(out_pixel), 0);
      chk("rst out_x", int'(out_x), 0);
      chk("rst out_y", int'(out_y), 0);
      chk("rst frame_done", int'(frame_done), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst z4", int'(z4), 0);
      reset = 1'b0;
      tick();
      chk("idle busy", int'(busy), 0);

      // Uniform 0x40 frame with FSM sequencing and frame_done timing.
      q_x.delete(); q_y.delete(); q_p.delete();
      for (int i = 0; i < 12; i++) pat[i] = 8'h40;
      exp_pix = '{255, 255, 255, 255, 255, 255};
      start_frame();
      chk("start busy", int'(busy), 1);
      chk("start state", int'(dut.state_q), int'(ST_FILL));
      for (int i = 0; i < 12; i++) begin
         pix_valid = 1'b1;
         pix_in    = pat[i];
         tick();
         if (i == 6)  chk("state after 7", int'(dut.state_q), int'(ST_FILL));
         if (i == 7)  chk("state after 8", int'(dut.state_q), int'(ST_RUN));
         if (i == 11) chk("state after 12", int'(dut.state_q), int'(ST_FLUSH));
      end
      pix_valid = 1'b0;
      tick();
      chk("flush+1 frame_done", int'(frame_done), 0);
      chk("flush+1 busy", int'(busy), 1);
      tick();
      chk("flush+2 frame_done", int'(frame_done), 0);
      chk("last out_valid", int'(out_valid), 1);
      chk("last out_x", int'(out_x), 2);
      chk("last out_y", int'(out_y), 1);
      tick();
      chk("flush+3 frame_done", int'(frame_done), 1);
      chk("flush+3 busy", int'(busy), 0);
      chk("flush+3 out_valid", int'(out_valid), 0);
      tick();
      chk("done pulse width", int'(frame_done), 0);
      chk("uniform z4", int'(z4), 8'h40);
      check_outputs("uniform");
      chk("uniform done count", done_cnt, 1);

      // Vertical step, no gaps.
      for (int i = 0; i < 12; i++) pat[i] = ((i % 4) < 2) ? 8'h00 : 8'hFF;
      exp_pix = '{255, 255, 255, 255, 0, 0};
      q_x.delete(); q_y.delete(); q_p.delete();
      start_frame();
      feed(12, 1'b0);
      repeat (6) tick();
      check_outputs("step");
      chk("step done count", done_cnt, 2);

      // Same step with pix_valid toggling: identical output sequence.
      q_x.delete(); q_y.delete(); q_p.delete();
      start_frame();
      feed(12, 1'b1);
      repeat (6) tick();
      check_outputs("step gaps");
      chk("gaps done count", done_cnt, 3);

      // Abort after pixel 6 (with a coincident pixel dropped), then full frame.
      for (int i = 0; i < 12; i++) pat[i] = (i == 6) ? 8'd200 : 8'd0;
      exp_pix = '{255, 255, 255, 255, 0, 255};
      q_x.delete(); q_y.delete(); q_p.delete();
      done_ref = done_cnt;
      start_frame();
      feed(6, 1'b0);
      frame_start = 1'b1; pix_valid = 1'b1; pix_in = 8'hC8;
      tick();
      frame_start = 1'b0; pix_valid = 1'b0;
      chk("abort state", int'(dut.state_q), int'(ST_FILL));
      chk("abort out_valid", int'(out_valid), 0);
      chk("abort busy", int'(busy), 1);
      feed(12, 1'b0);
      repeat (6) tick();
      check_outputs("after abort");
      chk("abort done count", done_cnt, done_ref + 1);

      // Reset during FLUSH discards the last output and frame_done.
      for (int i = 0; i < 12; i++) pat[i] = 8'h40;
      q_x.delete(); q_y.delete(); q_p.delete();
      done_ref = done_cnt;
      start_frame();
      feed(12, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      chk("flush rst out_valid", int'(out_valid), 0);
      chk("flush rst frame_done", int'(frame_done), 0);
      chk("flush rst busy", int'(busy), 0);
      reset = 1'b0;
      repeat (5) tick();
      chk("flush rst done count", done_cnt, done_ref);
      chk("flush rst out count", q_p.size(), 5);
      chk("flush rst state", int'(dut.state_q), int'(ST_IDLE));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
